// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared types, limits and the byte-merge helper for the RAM bank.
package ram_bank_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} bank_state_t;
  localparam int MAX_RD_LATENCY = 4;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH = MAX_DATA_WIDTH / 8;
  // Callers zero-extend narrower words into the fixed-width arguments and truncate the result.
  function automatic logic [MAX_DATA_WIDTH-1:0] be_merge(
    input logic [MAX_DATA_WIDTH-1:0] old,
    input logic [MAX_DATA_WIDTH-1:0] wdata,
    input logic [MAX_BE_WIDTH-1:0] be
  );
    logic [MAX_DATA_WIDTH-1:0] r;
    for (int i = 0; i < MAX_BE_WIDTH; i++) r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: fixed-depth shift register that delays read responses {valid, data, err}.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_err,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_err
);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] e;
  logic [DATA_WIDTH-1:0] d [DEPTH];
  // Idle stages carry zero data and error so the outputs read 0 whenever valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid && in_err;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_err = e[DEPTH-1];
  assign out_data = d[DEPTH-1];
endmodule

// File: rtl/ram_bank_ctrl.sv
// ram_bank_ctrl: single-port RAM bank with byte-enabled writes, delayed reads and a hardware clear sweep.
module ram_bank_ctrl
  import ram_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int ADDR_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  localparam int BE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);
  localparam int CW = $clog2(ADDR_DEPTH + 1);
  localparam int IW = ADDR_DEPTH > 1 ? $clog2(ADDR_DEPTH) : 1;
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
    $error("RD_LATENCY must be in 1..%0d", MAX_RD_LATENCY);
  end
  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8 and at most %0d", MAX_DATA_WIDTH);
  end
  if (ADDR_DEPTH < 1 || ADDR_DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("ADDR_DEPTH must be in 1..2**ADDR_WIDTH");
  end
  bank_state_t state;
  bank_state_t state_nxt;
  logic [CW-1:0] cnt;
  logic clearing;
  logic accept;
  logic in_range;
  logic [IW-1:0] aidx;
  logic [IW-1:0] cidx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CLEAR;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == ST_CLEAR ? (cnt == CW'(ADDR_DEPTH - 1) ? ST_READY : ST_CLEAR)
                                  : (clr_req ? ST_CLEAR : ST_READY);
  end
  always_comb begin
    clearing = state == ST_CLEAR;
    init_done = state == ST_READY;
    req_ready = state == ST_READY && !clr_req;
  end
  // The counter rests at 0 in READY, so entering CLEAR always sweeps from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= clearing ? cnt + CW'(1) : '0;
  end
  assign accept = req_valid && req_ready;
  assign in_range = 32'(req_addr) < 32'(ADDR_DEPTH);
  assign aidx = IW'(req_addr);
  assign cidx = IW'(cnt);
  assign rd_data = in_range ? mem[aidx] : '0;
  // Storage has no reset; the clear sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (clearing) mem[cidx] <= '0;
    else if (accept && req_we && in_range)
      mem[aidx] <= DATA_WIDTH'(be_merge(MAX_DATA_WIDTH'(mem[aidx]), MAX_DATA_WIDTH'(req_wdata), MAX_BE_WIDTH'(req_be)));
  end
  ram_rd_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(RD_LATENCY)
  ) u_rd_pipe (
    .clk(clk),
    .rst(rst),
    .in_valid(accept && !req_we),
    .in_data(rd_data),
    .in_err(!in_range),
    .out_valid(rsp_valid),
    .out_data(rsp_rdata),
    .out_err(rsp_err)
  );
endmodule

// File: tb/tb_ram_bank_ctrl.sv
// tb_ram_bank_ctrl: directed and randomized checks of ram_bank_ctrl against a behavioural bank model.
module tb_ram_bank_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 12;
  localparam int DW = 32;
  localparam int LAT = 3;
  typedef struct {
    int due;
    logic [DW-1:0] d;
    logic e;
  } rsp_t;
  logic clk = 0;
  logic rst = 1;
  logic clr_req = 0;
  logic req_valid = 0;
  logic req_ready;
  logic req_we = 0;
  logic [AW-1:0] req_addr = 0;
  logic [DW-1:0] req_wdata = 0;
  logic [DW/8-1:0] req_be = 0;
  logic rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic rsp_err;
  logic init_done;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int clear_left = DEPTH;
  logic m_rdy;
  logic [DW-1:0] mm [DEPTH];
  rsp_t q[$];
  int low_run = 0;
  int last_run = 0;
  ram_bank_ctrl #(
    .ADDR_WIDTH(AW),
    .ADDR_DEPTH(DEPTH),
    .DATA_WIDTH(DW),
    .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr_req(clr_req),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .init_done(init_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask
  // Model: the bank is READY once DEPTH clear cycles have elapsed; reads are captured
  // as (due cycle, data, err) entries at acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      clear_left = DEPTH;
      foreach (mm[i]) mm[i] = '0;
    end else begin
      cyc++;
      m_rdy = clear_left == 0 && !clr_req;
      if (clear_left > 0) clear_left--;
      else if (clr_req) begin
        clear_left = DEPTH;
        foreach (mm[i]) mm[i] = '0;
      end
      if (m_rdy && req_valid) begin
        if (req_we) begin
          if (int'(req_addr) < DEPTH)
            for (int b = 0; b < DW / 8; b++) if (req_be[b]) mm[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end else if (int'(req_addr) < DEPTH) q.push_back('{due: cyc + LAT - 1, d: mm[req_addr], e: 1'b0});
        else q.push_back('{due: cyc + LAT - 1, d: '0, e: 1'b1});
      end
    end
  end
  always @(negedge clk) begin
    logic ev;
    logic [DW-1:0] ed;
    logic ee;
    if (rst) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_init_done", init_done, 0);
    end else begin
      ev = 0;
      ed = '0;
      ee = 0;
      if (q.size() != 0 && q[0].due == cyc) begin
        ev = 1;
        ed = q[0].d;
        ee = q[0].e;
        void'(q.pop_front());
      end
      chk("rsp_valid", rsp_valid, ev);
      chk("rsp_rdata", rsp_rdata, ed);
      chk("rsp_err", rsp_err, ee);
      chk("init_done", init_done, clear_left == 0);
      chk("req_ready", req_ready, clear_left == 0 && !clr_req);
    end
  end
  always @(negedge clk) begin
    if (rst) low_run = 0;
    else if (!init_done) low_run++;
    else if (low_run != 0) begin
      last_run = low_run;
      low_run = 0;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("init_timeout", n < 100, 1);
    step();
  endtask
  task automatic wait_rsp(output logic [DW-1:0] d, output logic e);
    int n = 0;
    d = 'x;
    e = 1'bx;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        d = rsp_rdata;
        e = rsp_err;
        break;
      end
    end
    chk("rsp_timeout", n < 10, 1);
    step();
  endtask
  task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    req_valid = 1;
    req_we = 1;
    req_addr = AW'(a);
    req_wdata = d;
    req_be = be;
    step();
    req_valid = 0;
  endtask
  task automatic rd(input int a, output logic [DW-1:0] d, output logic e);
    req_valid = 1;
    req_we = 0;
    req_addr = AW'(a);
    step();
    req_valid = 0;
    wait_rsp(d, e);
  endtask
  initial begin
    logic [DW-1:0] d;
    logic e;
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    wait_init();
    chk("init_cycles", last_run, DEPTH);
    rd(0, d, e);
    chk("rd0_data", d, 0);
    chk("rd0_err", e, 0);
    wr(3, 32'hAABBCCDD, 4'hF);
    wr(3, 32'h11223344, 4'b0101);
    rd(3, d, e);
    chk("be_merge", d, 32'hAA22CC44);
    wr(7, 32'h77, 4'hF);
    rd(7, d, e);
    chk("raw", d, 32'h77);
    wr(1, 32'h101, 4'hF);
    wr(2, 32'h202, 4'hF);
    wr(3, 32'h303, 4'hF);
    req_valid = 1;
    req_we = 0;
    for (int i = 1; i <= 3; i++) begin
      req_addr = AW'(i);
      step();
    end
    req_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_data", rsp_rdata, 32'h101 * i);
    end
    step();
    rd(13, d, e);
    chk("oor_data", d, 0);
    chk("oor_err", e, 1);
    wr(14, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < DEPTH; i++) rd(i, d, e);
    rd(0, d, e);
    chk("oor_wr_dropped", d, 0);
    wr(5, 32'h55, 4'hF);
    req_valid = 1;
    req_we = 0;
    req_addr = 5;
    step();
    req_valid = 0;
    clr_req = 1;
    step();
    clr_req = 0;
    wait_rsp(d, e);
    chk("clr_inflight", d, 32'h55);
    wait_init();
    chk("clr_cycles", last_run, DEPTH);
    rd(5, d, e);
    chk("clr_zeroed", d, 0);
    wr(4, 32'h44, 4'hF);
    req_valid = 1;
    req_we = 0;
    req_addr = 4;
    step();
    req_addr = 3;
    step();
    req_valid = 0;
    rst = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst_flush", seen, 0);
    step();
    rst = 0;
    wait_init();
    chk("rst_sweep", last_run, DEPTH);
    rd(4, d, e);
    chk("rst_zeroed", d, 0);
    repeat (3000) begin
      req_valid = $urandom_range(0, 3) != 0;
      req_we = $urandom_range(0, 1) == 1;
      req_addr = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_be = 4'($urandom_range(0, 15));
      clr_req = $urandom_range(0, 60) == 0;
      step();
    end
    req_valid = 0;
    clr_req = 0;
    repeat (20) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
